// File: rtl/fir_tap_accumulator.sv
// Multi-cycle signed reduction of a packed product vector, LANES elements per beat.
// Optional clamping of the narrowed result is enabled by defining FIR_ACC_SAT_EN.
module fir_tap_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_COUNT = 8,
    parameter int LANES      = 2,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH*DATA_COUNT-1:0] data_in,
    input  logic                             valid_in,
    output logic                             ready_out,
    output logic [OUT_WIDTH-1:0]             data_out,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic                             sat_out
);

    localparam int ACC_WIDTH = DATA_WIDTH + $clog2(DATA_COUNT);
    localparam int N         = DATA_COUNT / LANES;
    localparam int CNT_W     = (N > 1) ? $clog2(N) : 1;
    localparam int BEAT_W    = LANES * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                          state_reg;
    logic [DATA_WIDTH*DATA_COUNT-1:0] hold_reg;
    logic signed [ACC_WIDTH-1:0]     acc_reg;
    logic [CNT_W-1:0]                beat_reg;
    logic [OUT_WIDTH-1:0]            data_out_reg;
    logic                            valid_out_reg;
    logic                            sat_out_reg;

    logic                            accept;
    logic                            last_beat;
    logic [BEAT_W-1:0]               beat_slices [N];
    logic [BEAT_W-1:0]               beat_slice;
    logic signed [ACC_WIDTH-1:0]     lane_ext [LANES];
    logic signed [ACC_WIDTH-1:0]     sum_next;
    logic [OUT_WIDTH-1:0]            reduced;
    logic                            reduced_sat;

    // Reset dominates: nothing is accepted on a cycle that is being reset.
    assign ready_out = !rst && ((state_reg == IDLE) || ((state_reg == OUT) && ready_in));
    assign accept    = valid_in && ready_out;
    assign last_beat = (beat_reg == CNT_W'(N - 1));

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_beat
            assign beat_slices[gi] = hold_reg[gi*BEAT_W +: BEAT_W];
        end
    endgenerate

    assign beat_slice = beat_slices[beat_reg];

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0] elem;
            assign elem         = beat_slice[gi*DATA_WIDTH +: DATA_WIDTH];
            assign lane_ext[gi] = ACC_WIDTH'(elem);
        end
    endgenerate

    // ACC_WIDTH carries log2(DATA_COUNT) guard bits, so this sum never overflows.
    always_comb begin
        sum_next = acc_reg;
        for (int i = 0; i < LANES; i++) begin
            sum_next = sum_next + lane_ext[i];
        end
    end

    generate
        if (OUT_WIDTH >= ACC_WIDTH) begin : g_extend
            assign reduced     = OUT_WIDTH'(sum_next);
            assign reduced_sat = 1'b0;
        end else begin : g_narrow
`ifdef FIR_ACC_SAT_EN
            localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
                {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
            localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
                {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
            always_comb begin
                reduced     = sum_next[OUT_WIDTH-1:0];
                reduced_sat = 1'b0;
                if (sum_next > SAT_MAX) begin
                    reduced     = SAT_MAX[OUT_WIDTH-1:0];
                    reduced_sat = 1'b1;
                end else if (sum_next < SAT_MIN) begin
                    reduced     = SAT_MIN[OUT_WIDTH-1:0];
                    reduced_sat = 1'b1;
                end
            end
`else
            assign reduced     = sum_next[OUT_WIDTH-1:0];
            assign reduced_sat = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            acc_reg       <= '0;
            beat_reg      <= '0;
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
            sat_out_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        hold_reg  <= data_in;
                        acc_reg   <= '0;
                        beat_reg  <= '0;
                        state_reg <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_reg <= sum_next;
                    if (last_beat) begin
                        data_out_reg  <= reduced;
                        sat_out_reg   <= reduced_sat;
                        valid_out_reg <= 1'b1;
                        state_reg     <= OUT;
                    end else begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                OUT: begin
                    if (ready_in) begin
                        valid_out_reg <= 1'b0;
                        // Back-to-back: the output handshake also admits the next vector.
                        if (valid_in) begin
                            hold_reg  <= data_in;
                            acc_reg   <= '0;
                            beat_reg  <= '0;
                            state_reg <= ACCUM;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    valid_out_reg <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_reg;
    assign valid_out = valid_out_reg;
    assign sat_out   = sat_out_reg;

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Directed bench for fir_tap_accumulator at default parameters (16/8/2/16, four beats).
// Expected saturation behaviour follows whether FIR_ACC_SAT_EN is defined for the build.
module tb_fir_tap_accumulator;

    logic         clk;
    logic         rst;
    logic [127:0] data_in;
    logic         valid_in;
    logic         ready_out;
    logic [15:0]  data_out;
    logic         valid_out;
    logic         ready_in;
    logic         sat_out;

    int n_checks;
    int n_fail;

    fir_tap_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .sat_out   (sat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fill(input int v);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'(v);
        return r;
    endfunction

    function automatic logic [127:0] pack8(input int a, input int b, input int c, input int d,
                                           input int e, input int f, input int g, input int h);
        return {16'(h), 16'(g), 16'(f), 16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Accept one vector from IDLE with ready_in=1 and follow it to completion.
    task automatic run_vector(input string tag, input logic [127:0] vec,
                              input logic [15:0] exp_d, input logic exp_s);
        data_in  = vec;
        valid_in = 1'b1;
        check({tag, ".ready_idle"}, 32'(ready_out), 32'd1);
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, ".valid_busy"}, 32'(valid_out), 32'd0);
            check({tag, ".ready_busy"}, 32'(ready_out), 32'd0);
            step();
        end
        check({tag, ".valid"}, 32'(valid_out), 32'd1);
        check({tag, ".data"}, 32'(data_out), 32'(exp_d));
        check({tag, ".sat"}, 32'(sat_out), 32'(exp_s));
        $display("result %s data_out=%04h sat_out=%0d", tag, data_out, sat_out);
        step();
        check({tag, ".valid_drop"}, 32'(valid_out), 32'd0);
        check({tag, ".ready_back"}, 32'(ready_out), 32'd1);
    endtask

    logic [127:0] tp_vec [3];
    logic [15:0]  tp_exp [3];
    int           tp_k;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        data_in  = '0;
        step();
        step();

        // Reset state
        check("rst.valid", 32'(valid_out), 32'd0);
        check("rst.data", 32'(data_out), 32'd0);
        check("rst.sat", 32'(sat_out), 32'd0);
        check("rst.ready_forced", 32'(ready_out), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.ready_idle", 32'(ready_out), 32'd1);

        run_vector("ones", fill(1), 16'd8, 1'b0);
        run_vector("alt", pack8(100, -200, 300, -400, 500, -600, 700, -800), 16'hFE70, 1'b0);
`ifdef FIR_ACC_SAT_EN
        run_vector("max", fill(32767), 16'h7FFF, 1'b1);
        run_vector("min", fill(-32768), 16'h8000, 1'b1);
`else
        run_vector("max", fill(32767), 16'hFFF8, 1'b0);
        run_vector("min", fill(-32768), 16'h0000, 1'b0);
`endif

        // Backpressure: result of all-3s held while a second vector waits.
        ready_in = 1'b0;
        data_in  = fill(3);
        valid_in = 1'b1;
        step();
        data_in = pack8(1, 2, 3, 4, 5, 6, 7, 8);
        for (int i = 0; i < 4; i++) begin
            check("bp.valid_busy", 32'(valid_out), 32'd0);
            step();
        end
        check("bp.valid", 32'(valid_out), 32'd1);
        check("bp.data", 32'(data_out), 32'd24);
        $display("result bp.first data_out=%04h sat_out=%0d", data_out, sat_out);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.hold_valid", 32'(valid_out), 32'd1);
            check("bp.hold_data", 32'(data_out), 32'd24);
            check("bp.hold_ready", 32'(ready_out), 32'd0);
        end
        ready_in = 1'b1;
        #1;
        check("bp.ready_follow", 32'(ready_out), 32'd1);
        step();
        valid_in = 1'b0;
        check("bp.valid_drop", 32'(valid_out), 32'd0);
        check("bp.second_taken", 32'(ready_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp.second_busy", 32'(valid_out), 32'd0);
        end
        step();
        check("bp.second_valid", 32'(valid_out), 32'd1);
        check("bp.second_data", 32'(data_out), 32'd36);
        $display("result bp.second data_out=%04h sat_out=%0d", data_out, sat_out);
        step();
        check("bp.idle", 32'(ready_out), 32'd1);

        // Sustained throughput: three vectors, results expected at cycles 4, 9, 14.
        tp_vec[0] = fill(1);
        tp_vec[1] = pack8(10, 20, 30, 40, 50, 60, 70, 80);
        tp_vec[2] = fill(-5);
        tp_exp[0] = 16'd8;
        tp_exp[1] = 16'd360;
        tp_exp[2] = 16'hFFD8;
        tp_k      = 0;
        data_in   = tp_vec[0];
        valid_in  = 1'b1;
        step();
        for (int t = 1; t <= 30; t++) begin
            step();
            if (valid_out && tp_k < 3) begin
                check("tp.cycle", 32'(t), 32'(4 + 5 * tp_k));
                check("tp.data", 32'(data_out), 32'(tp_exp[tp_k]));
                $display("result tp.%0d cycle=%0d data_out=%04h", tp_k, t, data_out);
                if (tp_k < 2) data_in = tp_vec[tp_k + 1];
                else valid_in = 1'b0;
                tp_k++;
            end
        end
        check("tp.count", 32'(tp_k), 32'd3);
        valid_in = 1'b0;
        step();

        // Reset during beat 2 discards the partial sum.
        data_in  = fill(7);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mr.ready_forced", 32'(ready_out), 32'd0);
        step();
        rst = 1'b0;
        check("mr.valid", 32'(valid_out), 32'd0);
        #1;
        check("mr.idle", 32'(ready_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mr.no_stale", 32'(valid_out), 32'd0);
        end
        run_vector("twos", fill(2), 16'd16, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_tap_accumulator.md
# fir_tap_accumulator

Multi-cycle signed reduction stage for the FIR datapath. It sits directly downstream of the packed-vector pipeline register and consumes its `DATA_COUNT` tap products (flattened `DATA_WIDTH*DATA_COUNT` bus). It sums the products `LANES` at a time over several cycles and presents one filter output sample to the downstream sink through a valid/ready handshake. Trading cycles for adders keeps the adder count at `LANES` rather than a full `DATA_COUNT`-input tree.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: width of each signed product element.
- `DATA_COUNT`, default 8: number of elements per input vector; must be a multiple of `LANES`.
- `LANES`, default 2: elements summed per accumulate cycle.
- `OUT_WIDTH`, default 16: width of the signed result on `data_out`.
- `ACC_WIDTH` (localparam): `DATA_WIDTH + $clog2(DATA_COUNT)`, full-precision accumulator.
- `N` (localparam): `DATA_COUNT/LANES`, the number of accumulate beats.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `data_in`, input, `DATA_WIDTH*DATA_COUNT`: element k is `data_in[k*DATA_WIDTH +: DATA_WIDTH]`, two's complement.
- `valid_in`, input, 1: `data_in` is valid.
- `ready_out`, output, 1: block accepts `data_in` this cycle.
- `data_out`, output, `OUT_WIDTH`: signed sum of the accepted vector.
- `valid_out`, output, 1: `data_out` is valid.
- `ready_in`, input, 1: downstream accepts `data_out`.
- `sat_out`, output, 1: result was clipped; qualified by `valid_out`.

## Operation
- FSM states are IDLE, ACCUM and OUT. Reset puts the FSM in IDLE.
- Reset values: `data_out`=0, `valid_out`=0, `sat_out`=0, accumulator=0, beat counter=0.
- `ready_out` is combinational:
  - 1 in IDLE.
  - Equal to `ready_in` in OUT.
  - 0 in ACCUM.
  - Forced to 0 while `rst` is high.
- Input accept (`valid_in & ready_out`):
  - Latch the whole vector into a holding register.
  - Clear the accumulator and set the beat counter to 0.
  - Go to ACCUM.
- ACCUM, beat b:
  - Add elements `b*LANES` through `b*LANES+LANES-1`, each sign-extended to `ACC_WIDTH`.
  - The addition cannot overflow at `ACC_WIDTH`.
- ACCUM, last beat (b = N-1):
  - Load `data_out`/`sat_out` from the final sum after width reduction.
  - Set `valid_out` and go to OUT.
  - For every other beat, increment b.
- OUT: hold `data_out`, `sat_out` and `valid_out` stable until `ready_in`=1.
- On output handshake (`valid_out & ready_in`):
  - If `valid_in` is also 1, accept the new vector in the same cycle and go to ACCUM.
  - Otherwise go to IDLE.
  - In both cases `valid_out` drops to 0 after the edge.
- Width reduction from `ACC_WIDTH` to `OUT_WIDTH` follows the Configuration section. If `OUT_WIDTH >= ACC_WIDTH`, the sum is sign-extended and `sat_out` stays 0.
- `valid_in` while `ready_out`=0 is ignored. The upstream stage holds its data.

## Timing
- Vector accepted at edge E: accumulate beats occur at edges E+1 through E+N.
- `valid_out` is high from edge E+N onward, so latency is N cycles (4 at defaults).
- Sustained throughput with `ready_in`=1 and `valid_in`=1: one result every N+1 cycles.
- Reset mid-operation: at the next edge the FSM returns to IDLE, `valid_out` goes to 0 and the partial sum is discarded. No stale result is ever emitted.
- `rst` overrides any simultaneous handshake.

## Configuration
- Macro: `FIR_ACC_SAT_EN`.
- Defined:
  - A result above `2^(OUT_WIDTH-1)-1` or below `-2^(OUT_WIDTH-1)` is clamped to that bound, with `sat_out`=1.
  - Otherwise `sat_out`=0.
- Undefined:
  - `data_out` takes the low `OUT_WIDTH` bits of the sum, i.e. wraps.
  - `sat_out` is tied to 0.
  - No comparator logic is generated.

## Test plan
All scenarios use the defaults: 16/8/2/16, N=4.
- Eight elements of 1 with `ready_in`=1 -> `valid_out` rises 4 cycles after accept, `data_out`=8, `sat_out`=0.
- Elements [100,-200,300,-400,500,-600,700,-800] -> `data_out`=-400 (0xFE70).
- All elements 32767 -> with macro, `data_out`=32767 and `sat_out`=1; without macro, `data_out`=0xFFF8 (-8) and `sat_out`=0.
- Result pending with `ready_in` low for 5 cycles and a second vector presented:
  - `data_out` stays stable and `ready_out`=0 throughout.
  - When `ready_in` rises, the second vector is accepted in that same cycle.
  - Its result appears 4 cycles later.
- `valid_in` and `ready_in` held at 1 across 3 vectors -> results arrive exactly 5 cycles apart with the correct sums.
- `rst` pulsed during beat 2 -> `valid_out`=0 and the FSM is in IDLE at the next edge. The following vector of all 2s yields 16.
